// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Purpose : bundles the fetch front end's pipeline and instruction-memory
//           signals so the queue and its environment share one port.
// Signals :
//   branch_to_new / branch_pc : redirect request and target from execute
//   stall                     : decode cannot accept the head instruction
//   imem_req / imem_addr      : fetch request and word address
//   imem_gnt                  : memory accepts the request this cycle
//   imem_rvalid / imem_rdata  : in-order read response
//   pc / inst / inst_valid    : head instruction presented to decode
//   queue_count               : FIFO occupancy
// Modports: master = fetch queue, slave = memory/pipeline environment.
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          branch_to_new;
  logic [15:0]   branch_pc;
  logic          stall;
  logic          imem_req;
  logic [15:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [15:0]   imem_rdata;
  logic [15:0]   pc;
  logic [15:0]   inst;
  logic          inst_valid;
  logic [CW-1:0] queue_count;

  modport master (
    input  branch_to_new, branch_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, pc, inst, inst_valid, queue_count
  );

  modport slave (
    output branch_to_new, branch_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, pc, inst, inst_valid, queue_count
  );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Purpose : instruction fetch front end. Issues sequential word-addressed
//           fetches with at most one request in flight, buffers returned
//           words with their PCs in a DEPTH-entry FIFO and presents the head
//           entry to decode. A redirect flushes the FIFO and marks any
//           in-flight response for discard.
// Ports   :
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   bus   : fetch_queue_if.master (pipeline + instruction memory signals)
// Parameters:
//   DEPTH    : FIFO entries, power of two, >= 2
//   RESET_PC : first fetch address after reset
// -----------------------------------------------------------------------------

// Overflow checker: the issue throttle must make every push find a free slot.
module fetch_queue_chk #(
  parameter int DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     push,
  input logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(push && (count == CW'(DEPTH)))
  );
endmodule

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic            clk,
  input logic            rst_n,
  fetch_queue_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Fetch-side state
  logic [15:0]   r_fpc;
  logic [15:0]   r_opc;
  logic          r_outstanding;
  logic          r_discard;

  // FIFO state
  logic [15:0]   r_mem_pc   [DEPTH];
  logic [15:0]   r_mem_inst [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Combinational qualifiers
  logic [CW:0]   w_occ;
  logic          w_room;
  logic          w_req;
  logic          w_fire;
  logic          w_resp;
  logic          w_push;
  logic          w_inst_valid;
  logic          w_pop;
  logic [15:0]   w_head_pc;
  logic [15:0]   w_head_inst;

  // Issue, response and pop qualifiers.
  always_comb begin
    // The in-flight request already owns a slot, so it counts against room.
    // A pop in the same cycle is deliberately not credited.
    w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_outstanding};
    w_room = (w_occ < (CW+1)'(DEPTH));

    // rst_n is active-high: no request may be shown while reset is held.
    // A new request may go out in the same cycle the previous one returns.
    w_req  = !rst_n && !bus.branch_to_new &&
             (!r_outstanding || bus.imem_rvalid) && w_room;
    w_fire = w_req && bus.imem_gnt;

    // Responses with nothing outstanding (e.g. lost across a reset) are ignored.
    w_resp = bus.imem_rvalid && r_outstanding;

    // A response is queued unless it is stale or arrives with a redirect.
    w_push = w_resp && !r_discard && !bus.branch_to_new;

    w_inst_valid = (r_count != '0) && !bus.branch_to_new;
    w_pop        = w_inst_valid && !bus.stall;
  end

  // Head entry mux: zero when the FIFO is empty.
  always_comb begin
    if (r_count != '0) begin
      w_head_pc   = r_mem_pc[r_rd_ptr];
      w_head_inst = r_mem_inst[r_rd_ptr];
    end else begin
      w_head_pc   = 16'h0000;
      w_head_inst = 16'h0000;
    end
  end

  // Fetch PC, in-flight request and stale-response tracking.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_fpc         <= RESET_PC;
      r_opc         <= 16'h0000;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      if (bus.branch_to_new) begin
        r_fpc <= bus.branch_pc;
      end else if (w_fire) begin
        r_fpc <= r_fpc + 16'h0001;
      end

      // A grant in the response cycle keeps one request in flight.
      if (w_fire) begin
        r_outstanding <= 1'b1;
        r_opc         <= r_fpc;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
      end

      // Set when a redirect leaves a request in flight; cleared by the
      // response it refers to. Repeated redirects keep it set.
      if (bus.branch_to_new && r_outstanding && !bus.imem_rvalid) begin
        r_discard <= 1'b1;
      end else if (w_resp) begin
        r_discard <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.branch_to_new) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through the count-gated head mux.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_opc;
      r_mem_inst[r_wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fpc;
  assign bus.inst_valid  = w_inst_valid;
  assign bus.pc          = w_head_pc;
  assign bus.inst        = w_head_inst;
  assign bus.queue_count = r_count;

  fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst_n),
    .push  (w_push),
    .count (r_count)
  );
endmodule
